// File: rtl/apb_pkg.sv
// Shared definitions for the APB register slave: FSM states, register map
// indices and address decode helpers.
package apb_pkg;

    // Transfer FSM states
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned REG_WCNT = 14;
    localparam int unsigned REG_ID   = 15;

    // Width of the wait-state counter; WAIT_STATES is limited to 0..15
    localparam int unsigned WAIT_W   = 4;

    // Only the lowest 64 bytes of the slave window are decoded
    function automatic logic addr_in_range(input logic [31:0] addr);
        return addr[31:6] == 26'd0;
    endfunction

    // Word index of the register selected by a byte address
    function automatic logic [3:0] reg_index(input logic [31:0] addr);
        return addr[5:2];
    endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state down-counter for the APB access phase. Loaded in the setup
// cycle, decremented once per stalled access cycle, saturates at zero.
module apb_wait_counter
    import apb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              dec,
    input  logic [WAIT_W-1:0] load_val,
    output logic              zero
);

    logic [WAIT_W-1:0] count_q;

    // Load has priority over decrement; never wraps below zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/apb_reg_slave.sv
// APB3 register slave: 14 read/write registers, a committed-write counter
// at index 14 and a constant ID at index 15, with programmable wait states.
// Optional feature macro: APB_SLV_PSLVERR_EN enables PSLVERR on out-of-range
// accesses and writes to the read-only registers; without it PSLVERR is 0.
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);
    localparam logic [3:0]        IDX_WCNT  = 4'(REG_WCNT);
    localparam logic [3:0]        IDX_ID    = 4'(REG_ID);

    apb_state_e  state_q;
    logic        setup;
    logic        access;
    logic        cnt_zero;
    logic        cnt_dec;
    logic [3:0]  idx;
    logic        in_range;
    logic        is_ro;
    logic        wr_commit;
    logic [31:0] rd_val;
    logic [31:0] regs_q [REG_WCNT];
    logic [31:0] wcnt_q;

    // Byte-lane bits are irrelevant for word registers
    logic unused_addr_bits;
    assign unused_addr_bits = ^PADDR[1:0];

    assign setup    = PSEL & ~PENABLE;
    assign access   = (state_q == ACCESS) & PSEL & PENABLE;
    assign cnt_dec  = access & ~cnt_zero;
    assign PREADY   = access & cnt_zero;

    assign idx      = reg_index(PADDR);
    assign in_range = addr_in_range(PADDR);
    assign is_ro    = (idx >= IDX_WCNT);

    // Only in-range writes to the writable block ever change state
    assign wr_commit = PREADY & PWRITE & in_range & ~is_ro;

    apb_wait_counter u_wait_counter (
        .clk      (PCLK),
        .rst      (PRESET),
        .load     (setup),
        .dec      (cnt_dec),
        .load_val (WAIT_LOAD),
        .zero     (cnt_zero)
    );

    // Transfer FSM: a setup cycle opens an access, completion or a dropped
    // PSEL closes it; a fresh setup while in ACCESS restarts the wait count
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (setup) begin
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!PSEL) begin
                        state_q <= IDLE;
                    end else if (PENABLE && cnt_zero) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read/write register file
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < REG_WCNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_commit) begin
            regs_q[idx] <= PWDATA;
        end
    end

    // Committed-write counter, wraps naturally at 2^32
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wcnt_q <= '0;
        end else if (wr_commit) begin
            wcnt_q <= wcnt_q + 32'd1;
        end
    end

    // Register read mux; out-of-range addresses read as zero
    always_comb begin
        rd_val = '0;
        if (in_range) begin
            if (idx == IDX_ID) begin
                rd_val = ID_VALUE;
            end else if (idx == IDX_WCNT) begin
                rd_val = wcnt_q;
            end else begin
                rd_val = regs_q[idx];
            end
        end
    end

    // PRDATA is only driven during a read completion cycle
    always_comb begin
        PRDATA = '0;
        if (PREADY && !PWRITE) begin
            PRDATA = rd_val;
        end
    end

`ifdef APB_SLV_PSLVERR_EN
    logic bad_access;
    assign bad_access = ~in_range | (PWRITE & is_ro);
    assign PSLVERR    = PREADY & bad_access;
`else
    assign PSLVERR    = 1'b0;
`endif

endmodule

// File: tb/tb_apb_reg_slave.sv
// Self-checking bench for apb_reg_slave: two instances (0 and 3 wait states)
// driven by a shared APB bus with separate selects, checked against a
// word-array model of the register map.
module tb_apb_reg_slave;

    localparam logic [31:0] ID = 32'hA5B0_0001;
`ifdef APB_SLV_PSLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [1:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3;
    logic        pslverr0, pslverr3;

    int tests = 0;
    int fails = 0;

    always #5 PCLK = ~PCLK;

    apb_reg_slave #(.WAIT_STATES(0)) dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
    );

    apb_reg_slave #(.WAIT_STATES(3)) dut3 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
    );

    // Reference model: index 0 = dut0, index 1 = dut3
    logic [31:0] m_regs [2][14];
    logic [31:0] m_wcnt [2];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t tbl [12];

    function automatic int ws(input int w);
        return (w == 1) ? 3 : 0;
    endfunction

    function automatic logic ready_of(input int w);
        return (w == 1) ? pready3 : pready0;
    endfunction

    function automatic logic [31:0] rdata_of(input int w);
        return (w == 1) ? prdata3 : prdata0;
    endfunction

    function automatic logic slverr_of(input int w);
        return (w == 1) ? pslverr3 : pslverr0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 14; i++) m_regs[w][i] = '0;
            m_wcnt[w] = '0;
        end
    endtask

    // Apply one completed transfer to the model, returning what the bus should show
    task automatic model_op(input int w, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, output logic [31:0] rd, output bit err);
        int unsigned word;
        word = addr / 4;
        rd   = '0;
        err  = 1'b0;
        if (addr >= 32'd64) begin
            err = ERR_EN;
        end else if (wr) begin
            if (word >= 14) begin
                err = ERR_EN;
            end else begin
                m_regs[w][word] = data;
                m_wcnt[w]       = m_wcnt[w] + 32'd1;
            end
        end else begin
            if (word < 14)       rd = m_regs[w][word];
            else if (word == 14) rd = m_wcnt[w];
            else                 rd = ID;
        end
    endtask

    // One APB transfer; leaves the bus in its completion state (no idle cycle)
    task automatic xfer(input int w, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, output logic [31:0] rd,
                        output bit err, output int waits);
        bit done;
        done  = 1'b0;
        waits = 0;
        rd    = '0;
        err   = 1'b0;
        @(posedge PCLK); #1;
        psel    = (w == 1) ? 2'b10 : 2'b01;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(negedge PCLK);
        check("setup_pready", {31'b0, ready_of(w)}, 32'd0);
        @(posedge PCLK); #1;
        penable = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge PCLK);
            if (ready_of(w)) begin
                done = 1'b1;
                rd   = rdata_of(w);
                err  = slverr_of(w);
            end else begin
                waits++;
                check("wait_prdata", rdata_of(w), 32'd0);
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got PREADY=0 after 40 cycles expected PREADY=1");
        end
    endtask

    task automatic bus_idle();
        @(posedge PCLK); #1;
        psel    = 2'b00;
        penable = 1'b0;
    endtask

    task automatic op(input int w, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input string tag);
        logic [31:0] rd, exp_rd;
        bit          err, exp_err;
        int          waits;
        xfer(w, wr, addr, data, rd, err, waits);
        model_op(w, wr, addr, data, exp_rd, exp_err);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_slverr"}, {31'b0, err}, {31'b0, exp_err});
        check({tag, "_waits"}, 32'(waits), 32'(ws(w)));
    endtask

    initial begin
        logic [31:0] rd, ignore_rd, addr;
        bit          err, ignore_err;
        int          waits;
        bit          done;

        tbl[0]  = '{1'b1, 32'h10, 32'hA5A5_A5A5, 32'h0,         1'b0};
        tbl[1]  = '{1'b0, 32'h10, 32'h0,         32'hA5A5_A5A5, 1'b0};
        tbl[2]  = '{1'b0, 32'h38, 32'h0,         32'h1,         1'b0};
        tbl[3]  = '{1'b0, 32'h3C, 32'h0,         ID,            1'b0};
        tbl[4]  = '{1'b1, 32'h3C, 32'h0,         32'h0,         ERR_EN};
        tbl[5]  = '{1'b0, 32'h3C, 32'h0,         ID,            1'b0};
        tbl[6]  = '{1'b1, 32'h40, 32'hFFFF_FFFF, 32'h0,         ERR_EN};
        tbl[7]  = '{1'b0, 32'h40, 32'h0,         32'h0,         ERR_EN};
        tbl[8]  = '{1'b0, 32'h38, 32'h0,         32'h1,         1'b0};
        tbl[9]  = '{1'b1, 32'h38, 32'h0000_DEAD, 32'h0,         ERR_EN};
        tbl[10] = '{1'b0, 32'h38, 32'h0,         32'h1,         1'b0};
        tbl[11] = '{1'b0, 32'h00, 32'h0,         32'h0,         1'b0};

        PRESET  = 1'b0;
        psel    = 2'b00;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        model_reset();

        // Reset state
        #2 PRESET = 1'b1;
        #1;
        check("rst_pready0", {31'b0, pready0}, 32'd0);
        check("rst_pready3", {31'b0, pready3}, 32'd0);
        check("rst_prdata3", prdata3, 32'd0);
        check("rst_pslverr3", {31'b0, pslverr3}, 32'd0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;

        // Directed table on the 3-wait-state instance
        for (int i = 0; i < 12; i++) begin
            xfer(1, tbl[i].wr, tbl[i].addr, tbl[i].data, rd, err, waits);
            model_op(1, tbl[i].wr, tbl[i].addr, tbl[i].data, ignore_rd, ignore_err);
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d_slverr", i), {31'b0, err}, {31'b0, tbl[i].exp_err});
            check($sformatf("tbl%0d_waits", i), 32'(waits), 32'd3);
        end
        bus_idle();

        // Zero wait states: ready in the first access cycle
        op(0, 1'b1, 32'h04, 32'h0000_1111, "ws0_wr");
        op(0, 1'b0, 32'h04, 32'h0, "ws0_rd");
        bus_idle();

        // Reset during the wait phase of a write
        op(1, 1'b1, 32'h08, 32'h0BAD_F00D, "pre_rst_wr");
        bus_idle();
        @(posedge PCLK); #1;
        psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h1234_5678;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(negedge PCLK);
        check("midrst_wait_pready", {31'b0, pready3}, 32'd0);
        #2 PRESET = 1'b1;
        #1;
        check("midrst_pready", {31'b0, pready3}, 32'd0);
        check("midrst_prdata", prdata3, 32'd0);
        psel = 2'b00; penable = 1'b0;
        @(negedge PCLK);
        PRESET = 1'b0;
        model_reset();
        op(1, 1'b0, 32'h08, 32'h0, "midrst_rd08");
        op(1, 1'b0, 32'h38, 32'h0, "midrst_wcnt");
        bus_idle();

        // Back-to-back writes on both instances, then read-back
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 4; i++) op(w, 1'b1, 32'(i * 4), 32'(i + 1), "b2b_wr");
            for (int i = 0; i < 4; i++) op(w, 1'b0, 32'(i * 4), 32'h0, "b2b_rd");
            op(w, 1'b0, 32'h38, 32'h0, "b2b_wcnt");
            bus_idle();
        end

        // PSEL dropped mid-access: write must not commit nor count
        op(1, 1'b1, 32'h0C, 32'h0000_C0DE, "drop_pre");
        bus_idle();
        @(posedge PCLK); #1;
        psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hBAD0_BAD0;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(negedge PCLK);
        check("drop_pready", {31'b0, pready3}, 32'd0);
        @(posedge PCLK); #1;
        psel = 2'b00; penable = 1'b0;
        op(1, 1'b0, 32'h0C, 32'h0, "drop_rd0c");
        op(1, 1'b0, 32'h38, 32'h0, "drop_wcnt");
        bus_idle();

        // Randomized traffic against the model
        for (int n = 0; n < 80; n++) begin
            int w;
            w = int'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8) begin
                addr = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            end else begin
                addr = $urandom;
                if (addr < 32'd64) addr = addr | 32'h100;
            end
            op(w, 1'($urandom_range(0, 1)), addr, $urandom, "rnd");
            if ($urandom_range(0, 3) == 0) bus_idle();
        end
        for (int w = 0; w < 2; w++) op(w, 1'b0, 32'h38, 32'h0, "rnd_wcnt");
        bus_idle();

        // Reset landing in a completion cycle forces PREADY low at once
        @(posedge PCLK); #1;
        psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'h5555_AAAA;
        @(posedge PCLK); #1;
        penable = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge PCLK);
            done = pready3;
        end
        check("cplrst_reached", {31'b0, done}, 32'd1);
        #1 PRESET = 1'b1;
        #1;
        check("cplrst_pready", {31'b0, pready3}, 32'd0);
        check("cplrst_pslverr", {31'b0, pslverr3}, 32'd0);
        psel = 2'b00; penable = 1'b0;
        @(negedge PCLK);
        PRESET = 1'b0;
        model_reset();
        op(1, 1'b0, 32'h14, 32'h0, "cplrst_rd14");
        op(1, 1'b0, 32'h38, 32'h0, "cplrst_wcnt");
        bus_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
